// File: rtl/uart_msg_encoder_pkg.sv
// Framing constants and state encodings shared by the UART message encoder and decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_msg_encoder_pkg;

   localparam int DATAMAXBYTES = 10;

   localparam logic [7:0] SP_SYNC = 8'h7E;
   localparam logic [7:0] SP_ESC  = 8'h02;
   localparam logic [7:0] SP_END  = 8'h03;

   typedef enum logic [2:0] {
      M_IDLE,
      M_SYNC,
      M_BCNT,
      M_BODY,
      M_ESC,
      M_TAIL,
      M_DONE
   } msg_state_e;

   typedef enum logic [1:0] {
      H_IDLE,
      H_LOAD,
      H_WAIT
   } hs_state_e;

   // True for any byte that collides with a framing marker and must be escaped.
   function automatic logic is_special(input logic [7:0] b);
      return (b == SP_SYNC) || (b == SP_ESC) || (b == SP_END);
   endfunction

endpackage

// File: rtl/uart_msg_encoder_tx_byte_handshake.sv
// Moves one byte into the UART via ld_tx_data/tx_empty, with a per-phase timeout.
// Latency: load request one cycle after start with tx_empty high; done when the UART reports empty again.
// Backpressure: holds ld_tx_data until the UART accepts; aborts if a phase exceeds ACK_TIMEOUT cycles.
module uart_tx_byte_handshake
   import uart_msg_encoder_pkg::*;
#(
   parameter int ACK_TIMEOUT = 5000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [7:0] byte_i,
   output logic       done_o,
   output logic       timeout_o,
   output logic       ld_tx_data_o,
   output logic [7:0] tx_data_o,
   input  logic       tx_empty_i
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1) + 1;

   hs_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    data_q, data_d;
   logic          expired;

   assign expired      = (cnt_q >= CW'(ACK_TIMEOUT));
   assign ld_tx_data_o = (state_q == H_LOAD) && rst_ni;
   assign tx_data_o    = data_q;

   // Phase sequencing; the byte is latched on entry to H_LOAD so tx_data stays stable until acceptance.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      done_o    = 1'b0;
      timeout_o = 1'b0;
      case (state_q)
         H_IDLE: begin
            if (start_i && tx_empty_i) begin
               state_d = H_LOAD;
               data_d  = byte_i;
            end
         end
         H_LOAD: begin
            if (!tx_empty_i) begin
               state_d = H_WAIT;
            end else if (expired) begin
               state_d   = H_IDLE;
               timeout_o = 1'b1;
            end
         end
         H_WAIT: begin
            if (tx_empty_i) begin
               state_d = H_IDLE;
               done_o  = 1'b1;
            end else if (expired) begin
               state_d   = H_IDLE;
               timeout_o = 1'b1;
            end
         end
         default: state_d = H_IDLE;
      endcase
      // The counter measures time spent in the current waiting phase only.
      if ((state_d != state_q) || (state_q == H_IDLE)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Phase register, timeout counter and held byte.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= H_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/uart_msg_encoder.sv
// Buffers payload bytes and sends them to the UART as SYNC, BCNT, escaped body, END.
// Latency: msg_busy rises the cycle after an accepted msg_send; one UART handshake per emitted byte.
// Backpressure: each byte waits on tx_empty; a stalled UART aborts the frame after ACK_TIMEOUT cycles.
module uart_msg_encoder
   import uart_msg_encoder_pkg::*;
#(
   parameter int DATAMAXBYTES = uart_msg_encoder_pkg::DATAMAXBYTES,
   parameter int ACK_TIMEOUT  = 5000
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       msg_wr,
   input  logic [7:0] msg_wr_data,
   input  logic       msg_send,
   output logic       msg_busy,
   output logic       msg_done,
   output logic       msg_err,
   output logic [3:0] wr_count,
   output logic       ld_tx_data,
   output logic [7:0] tx_data,
   output logic       tx_enable,
   input  logic       tx_empty
);

   localparam logic [3:0] MAXB = 4'(DATAMAXBYTES);

   msg_state_e state_q, state_d;
   msg_state_e ret_q, ret_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] bcnt_q, bcnt_d;
   logic [3:0] idx_q, idx_d;
   logic [3:0] nxt_idx;
   logic       err_q, err_d;
   logic       txen_q;
   logic       wr_en;
   logic       clr;
   logic [7:0] buf_q [DATAMAXBYTES];

   logic       hs_start;
   logic [7:0] hs_byte;
   logic       hs_done;
   logic       hs_timeout;

   assign msg_busy  = (state_q != M_IDLE) && (state_q != M_DONE);
   assign msg_done  = (state_q == M_DONE);
   assign msg_err   = err_q;
   assign wr_count  = cnt_q;
   assign tx_enable = txen_q;

   // Byte presented to the handshake for each emitting state.
   always_comb begin
      hs_start = 1'b1;
      hs_byte  = 8'h00;
      case (state_q)
         M_SYNC:  hs_byte = SP_SYNC;
         M_BCNT:  hs_byte = {4'b0000, bcnt_q};
         M_BODY:  hs_byte = buf_q[idx_q];
         M_ESC:   hs_byte = SP_ESC;
         M_TAIL:  hs_byte = SP_END;
         default: hs_start = 1'b0;
      endcase
   end

   // Frame sequencing; escape decisions are made when moving to the state that owns the byte.
   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      cnt_d   = cnt_q;
      bcnt_d  = bcnt_q;
      idx_d   = idx_q;
      err_d   = 1'b0;
      wr_en   = 1'b0;
      clr     = 1'b0;
      nxt_idx = idx_q + 4'd1;
      case (state_q)
         M_IDLE, M_DONE: begin
            state_d = M_IDLE;
            if (msg_wr) begin
               if (cnt_q < MAXB) begin
                  wr_en = 1'b1;
                  cnt_d = cnt_q + 4'd1;
               end else begin
                  err_d = 1'b1;
               end
            end
            // A same-cycle write is already counted, so it joins this frame.
            if (msg_send) begin
               if (cnt_d == 4'd0) begin
                  err_d = 1'b1;
               end else begin
                  state_d = M_SYNC;
                  bcnt_d  = cnt_d;
                  idx_d   = 4'd0;
               end
            end
         end
         M_SYNC: begin
            if (hs_done) begin
               state_d = is_special({4'b0000, bcnt_q}) ? M_ESC : M_BCNT;
               ret_d   = M_BCNT;
            end
         end
         M_BCNT: begin
            if (hs_done) begin
               state_d = is_special(buf_q[0]) ? M_ESC : M_BODY;
               ret_d   = M_BODY;
            end
         end
         M_BODY: begin
            if (hs_done) begin
               if (nxt_idx == bcnt_q) begin
                  state_d = M_TAIL;
               end else begin
                  idx_d   = nxt_idx;
                  state_d = is_special(buf_q[nxt_idx]) ? M_ESC : M_BODY;
                  ret_d   = M_BODY;
               end
            end
         end
         M_ESC: begin
            if (hs_done) state_d = ret_q;
         end
         M_TAIL: begin
            if (hs_done) begin
               state_d = M_DONE;
               clr     = 1'b1;
            end
         end
         default: state_d = M_IDLE;
      endcase
      if (msg_busy && msg_wr) err_d = 1'b1;
      if (hs_timeout) begin
         state_d = M_IDLE;
         err_d   = 1'b1;
         clr     = 1'b1;
      end
      if (clr) cnt_d = 4'd0;
   end

   // Frame state, counters, error pulse and the sticky transmit enable.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q <= M_IDLE;
         ret_q   <= M_IDLE;
         cnt_q   <= 4'd0;
         bcnt_q  <= 4'd0;
         idx_q   <= 4'd0;
         err_q   <= 1'b0;
         txen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         txen_q  <= 1'b1;
      end
   end

   // Payload buffer, written in arrival order and wiped at frame end or abort.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DATAMAXBYTES; i++) buf_q[i] <= 8'h00;
      end else if (clr) begin
         for (int i = 0; i < DATAMAXBYTES; i++) buf_q[i] <= 8'h00;
      end else if (wr_en) begin
         buf_q[cnt_q] <= msg_wr_data;
      end
   end

   uart_tx_byte_handshake #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_hs (
      .clk_i        (CLK),
      .rst_ni       (reset),
      .start_i      (hs_start),
      .byte_i       (hs_byte),
      .done_o       (hs_done),
      .timeout_o    (hs_timeout),
      .ld_tx_data_o (ld_tx_data),
      .tx_data_o    (tx_data),
      .tx_empty_i   (tx_empty)
   );

endmodule

// File: tb/tb_uart_msg_encoder.sv
// Directed and randomized checks of uart_msg_encoder against a queue-based frame model.
// Latency: n/a (testbench).
// Backpressure: UART model accepts and shifts with random delays, or stalls on demand.
module tb_uart_msg_encoder;

   localparam int T = 30;

   typedef logic [7:0] bq_t[$];

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic       msg_wr = 1'b0;
   logic [7:0] msg_wr_data = 8'h00;
   logic       msg_send = 1'b0;
   logic       tx_empty = 1'b1;
   logic       msg_busy, msg_done, msg_err, ld_tx_data, tx_enable;
   logic [3:0] wr_count;
   logic [7:0] tx_data;

   int   total = 0;
   int   bad = 0;
   bit   hold = 1'b0;
   bq_t  captured;
   logic [7:0] m_first;

   uart_msg_encoder #(.DATAMAXBYTES(10), .ACK_TIMEOUT(T)) dut (
      .CLK(CLK), .reset(reset), .msg_wr(msg_wr), .msg_wr_data(msg_wr_data),
      .msg_send(msg_send), .msg_busy(msg_busy), .msg_done(msg_done), .msg_err(msg_err),
      .wr_count(wr_count), .ld_tx_data(ld_tx_data), .tx_data(tx_data),
      .tx_enable(tx_enable), .tx_empty(tx_empty)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected wire bytes: SYNC, then count and payload with markers escaped, then END.
   function automatic bq_t frame_of(input bq_t pl);
      bq_t fr;
      bq_t body;
      body = pl;
      body.push_front(8'(pl.size()));
      fr.push_back(8'h7E);
      foreach (body[i]) begin
         if (body[i] inside {8'h7E, 8'h02, 8'h03}) fr.push_back(8'h02);
         fr.push_back(body[i]);
      end
      fr.push_back(8'h03);
      return fr;
   endfunction

   // UART transmitter model: accept a load after a random delay, then shift for a random time.
   always begin
      @(negedge CLK);
      if (reset && ld_tx_data && tx_empty && !hold) begin
         m_first = tx_data;
         repeat ($urandom_range(0, 3)) @(negedge CLK);
         if (ld_tx_data && !hold) begin
            chk("tx_data_stable", tx_data, m_first);
            captured.push_back(tx_data);
            tx_empty = 1'b0;
            repeat ($urandom_range(1, 5)) @(negedge CLK);
            tx_empty = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr_byte(input logic [7:0] b);
      msg_wr = 1'b1;
      msg_wr_data = b;
      tick();
      msg_wr = 1'b0;
   endtask

   task automatic start_send();
      captured.delete();
      msg_send = 1'b1;
      tick();
      msg_send = 1'b0;
      chk("busy_rise", {31'd0, msg_busy}, 1);
   endtask

   task automatic finish_frame(input string tag, input bq_t exp);
      int n;
      n = 0;
      while (!msg_done && !msg_err && n < 4000) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, {31'd0, msg_done}, 1);
      chk({tag, "_busy_low"}, {31'd0, msg_busy}, 0);
      chk({tag, "_count_clr"}, {28'd0, wr_count}, 0);
      chk({tag, "_len"}, captured.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         chk({tag, "_byte"}, (i < captured.size()) ? {24'd0, captured[i]} : 32'hDEAD, {24'd0, exp[i]});
      tick();
      chk({tag, "_done_pulse"}, {31'd0, msg_done}, 0);
   endtask

   task automatic send_payload(input string tag, input bq_t pl);
      foreach (pl[i]) wr_byte(pl[i]);
      start_send();
      finish_frame(tag, frame_of(pl));
   endtask

   function automatic bq_t rand_payload(input int len);
      bq_t pl;
      logic [7:0] sp[3];
      sp[0] = 8'h7E; sp[1] = 8'h02; sp[2] = 8'h03;
      for (int i = 0; i < len; i++)
         pl.push_back(($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 2)] : 8'($urandom));
      return pl;
   endfunction

   initial begin
      bq_t pl;
      int  n;
      bit  seen;

      // Reset state
      repeat (3) tick();
      chk("rst_busy", {31'd0, msg_busy}, 0);
      chk("rst_done", {31'd0, msg_done}, 0);
      chk("rst_err", {31'd0, msg_err}, 0);
      chk("rst_count", {28'd0, wr_count}, 0);
      chk("rst_ld", {31'd0, ld_tx_data}, 0);
      chk("rst_txen", {31'd0, tx_enable}, 0);
      reset = 1'b1;
      tick();
      chk("txen_after_rst", {31'd0, tx_enable}, 1);

      // Plain two-byte frame, BCNT itself needs escaping
      pl = '{8'h41, 8'h42};
      send_payload("f_4142", pl);

      // Markers in the body
      pl = '{8'h7E, 8'h03, 8'h10};
      send_payload("f_special", pl);

      // Overfill: eleventh write is dropped
      pl = rand_payload(10);
      foreach (pl[i]) wr_byte(pl[i]);
      chk("full_count", {28'd0, wr_count}, 10);
      wr_byte(8'hAA);
      chk("full_err", {31'd0, msg_err}, 1);
      chk("full_count_hold", {28'd0, wr_count}, 10);
      tick();
      start_send();
      finish_frame("f_full", frame_of(pl));

      // Empty send
      msg_send = 1'b1;
      tick();
      msg_send = 1'b0;
      chk("empty_err", {31'd0, msg_err}, 1);
      chk("empty_busy", {31'd0, msg_busy}, 0);
      seen = 1'b0;
      repeat (10) begin
         tick();
         if (ld_tx_data || msg_busy) seen = 1'b1;
      end
      chk("empty_no_frame", {31'd0, seen}, 0);

      // Random payloads
      for (int k = 0; k < 6; k++) begin
         pl = rand_payload($urandom_range(1, 10));
         send_payload("f_rand", pl);
      end

      // Write and send in the same cycle
      wr_byte(8'h55);
      captured.delete();
      msg_wr = 1'b1;
      msg_wr_data = 8'h03;
      msg_send = 1'b1;
      tick();
      msg_wr = 1'b0;
      msg_send = 1'b0;
      chk("wrsend_busy", {31'd0, msg_busy}, 1);
      pl = '{8'h55, 8'h03};
      finish_frame("f_wrsend", frame_of(pl));

      // Write while busy is dropped and flagged
      pl = '{8'h11, 8'h22};
      foreach (pl[i]) wr_byte(pl[i]);
      start_send();
      tick();
      tick();
      wr_byte(8'h99);
      chk("busy_wr_err", {31'd0, msg_err}, 1);
      chk("busy_wr_count", {28'd0, wr_count}, 2);
      tick();
      finish_frame("f_busywr", frame_of(pl));

      // Stalled UART: load never accepted
      hold = 1'b1;
      wr_byte(8'h61);
      wr_byte(8'h62);
      start_send();
      n = 0;
      while (!ld_tx_data && n < 100) begin
         tick();
         n++;
      end
      chk("to_ld_seen", {31'd0, ld_tx_data}, 1);
      n = 0;
      while (!msg_err && n < T + 20) begin
         tick();
         n++;
      end
      chk("to_cycles", n, T + 1);
      chk("to_ld_low", {31'd0, ld_tx_data}, 0);
      chk("to_busy_low", {31'd0, msg_busy}, 0);
      chk("to_count_clr", {28'd0, wr_count}, 0);
      tick();
      chk("to_err_pulse", {31'd0, msg_err}, 0);
      hold = 1'b0;
      repeat (10) tick();

      // Reset in the middle of the body
      pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
      foreach (pl[i]) wr_byte(pl[i]);
      start_send();
      n = 0;
      while (captured.size() < 4 && n < 500) begin
         tick();
         n++;
      end
      chk("mid_body_reached", {31'd0, captured.size() >= 4}, 1);
      reset = 1'b0;
      #1;
      chk("mid_rst_ld", {31'd0, ld_tx_data}, 0);
      chk("mid_rst_busy", {31'd0, msg_busy}, 0);
      chk("mid_rst_err", {31'd0, msg_err}, 0);
      chk("mid_rst_done", {31'd0, msg_done}, 0);
      chk("mid_rst_count", {28'd0, wr_count}, 0);
      chk("mid_rst_txen", {31'd0, tx_enable}, 0);
      repeat (3) tick();
      reset = 1'b1;
      repeat (20) tick();
      chk("post_rst_txen", {31'd0, tx_enable}, 1);
      pl = rand_payload(4);
      send_payload("f_post_rst", pl);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
